// File: rtl/cacheline_adaptor_if.sv
// Cache-side and memory-side signals of the cache line adaptor.
// The slave modport is the adaptor; the master modport is the cache/memory environment.
interface cacheline_adaptor_if;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic         resp_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic [63:0]  burst_o;
  logic [63:0]  burst_i;
  logic         resp_i;

  modport slave (
    input  address_i, read_i, write_i, line_i, burst_i, resp_i,
    output line_o, resp_o, address_o, read_o, write_o, burst_o
  );

  modport master (
    output address_i, read_i, write_i, line_i, burst_i, resp_i,
    input  line_o, resp_o, address_o, read_o, write_o, burst_o
  );
endinterface

// File: rtl/cacheline_adaptor.sv
// Bridges 256-bit cache line reads/writebacks onto a 4-beat x 64-bit memory burst.
// Writes take priority over reads; a pending read is picked up on the next IDLE cycle.
module cacheline_adaptor (
  input  logic              clk,
  input  logic              reset_n,
  cacheline_adaptor_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StDone
  } state_e;

  state_e       r_state, w_state_d;
  logic [1:0]   r_cnt, w_cnt_d;
  logic [26:0]  r_line_addr;
  logic [255:0] r_wb_line;
  logic [255:0] r_fill_line;
  logic         w_cap_wr;
  logic         w_cap_rd;
  logic         w_fill_we;
  logic [7:0]   w_beat_lsb;

  assign w_beat_lsb = {r_cnt, 6'b0};

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_cap_wr  = 1'b0;
    w_cap_rd  = 1'b0;
    w_fill_we = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.write_i) begin
          w_cap_wr  = 1'b1;
          w_cnt_d   = 2'd0;
          w_state_d = StWrite;
        end else if (bus.read_i) begin
          w_cap_rd  = 1'b1;
          w_cnt_d   = 2'd0;
          w_state_d = StRead;
        end
      end
      StRead: begin
        if (bus.resp_i) begin
          w_fill_we = 1'b1;
          w_cnt_d   = r_cnt + 2'd1;
          if (r_cnt == 2'd3) w_state_d = StDone;
        end
      end
      StWrite: begin
        if (bus.resp_i) begin
          w_cnt_d = r_cnt + 2'd1;
          if (r_cnt == 2'd3) w_state_d = StDone;
        end
      end
      StDone: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= StIdle;
      r_cnt       <= 2'd0;
      r_line_addr <= '0;
      r_wb_line   <= '0;
      r_fill_line <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      if (w_cap_wr || w_cap_rd) r_line_addr <= bus.address_i[31:5];
      if (w_cap_wr) r_wb_line <= bus.line_i;
      // Only the addressed beat slot changes; the rest of the fill line is held.
      if (w_fill_we) r_fill_line[w_beat_lsb +: 64] <= bus.burst_i;
    end
  end

  assign bus.read_o    = (r_state == StRead);
  assign bus.write_o   = (r_state == StWrite);
  assign bus.resp_o    = (r_state == StDone);
  assign bus.line_o    = r_fill_line;
  assign bus.address_o = (bus.read_o || bus.write_o) ? {r_line_addr, 5'b0} : 32'd0;
  assign bus.burst_o   = bus.write_o ? r_wb_line[w_beat_lsb +: 64] : 64'd0;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed self-checking bench for cacheline_adaptor: fills, writebacks, priority,
// mid-burst reset and stray memory acknowledges.
module tb_cacheline_adaptor;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;
  int   n_resp;

  cacheline_adaptor_if u_if ();

  cacheline_adaptor u_dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (u_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) if (u_if.resp_o === 1'b1) n_resp++;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Full read with contiguous acknowledges; optionally pulses resp_i during DONE.
  task automatic run_read(input string tag, input logic [31:0] addr, input logic [255:0] fill,
                          input bit junk_in_done);
    logic [31:0] exp_addr;
    exp_addr = {addr[31:5], 5'b0};
    u_if.address_i = addr;
    u_if.read_i    = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      check_eq({tag, "_read_o"}, u_if.read_o, 1'b1);
      check_eq({tag, "_addr_o"}, u_if.address_o, exp_addr);
      check_eq({tag, "_resp_o_busy"}, u_if.resp_o, 1'b0);
      u_if.resp_i  = 1'b1;
      u_if.burst_i = fill[64*k +: 64];
      step();
    end
    check_eq({tag, "_resp_o_done"}, u_if.resp_o, 1'b1);
    check_eq({tag, "_read_o_done"}, u_if.read_o, 1'b0);
    check_eq({tag, "_line_done"}, u_if.line_o, fill);
    u_if.read_i  = 1'b0;
    u_if.resp_i  = junk_in_done;
    u_if.burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
    step();
    u_if.resp_i = 1'b0;
    check_eq({tag, "_resp_o_after"}, u_if.resp_o, 1'b0);
    check_eq({tag, "_read_o_after"}, u_if.read_o, 1'b0);
    check_eq({tag, "_addr_o_after"}, u_if.address_o, 32'd0);
    check_eq({tag, "_line_held"}, u_if.line_o, fill);
  endtask

  logic [255:0] fill_a, fill_b, fill_c, wb_a, wb_b;
  int           n_wr;
  int           resp_mark;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    n_resp   = 0;
    fill_a = {{8{8'hA3}}, {8{8'hA2}}, {8{8'hA1}}, {8{8'hA0}}};
    fill_b = {{8{8'hB3}}, {8{8'hB2}}, {8{8'hB1}}, {8{8'hB0}}};
    fill_c = {64'hC3C3_0000_1111_C3C3, 64'hC2C2_2222_3333_C2C2,
              64'hC1C1_4444_5555_C1C1, 64'hC0C0_6666_7777_C0C0};
    wb_a   = 256'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0;
    wb_b   = {64'h5555_5555_5555_5555, 64'h4444_4444_4444_4444,
              64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222};

    u_if.address_i = '0;
    u_if.read_i    = 1'b0;
    u_if.write_i   = 1'b0;
    u_if.line_i    = '0;
    u_if.burst_i   = '0;
    u_if.resp_i    = 1'b0;
    reset_n        = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    check_eq("rst_read_o", u_if.read_o, 1'b0);
    check_eq("rst_write_o", u_if.write_o, 1'b0);
    check_eq("rst_resp_o", u_if.resp_o, 1'b0);
    check_eq("rst_addr_o", u_if.address_o, 32'd0);
    check_eq("rst_burst_o", u_if.burst_o, 64'd0);
    check_eq("rst_line_o", u_if.line_o, 256'd0);
    step();
    reset_n = 1'b1;
    step();

    // Read fill with contiguous beats.
    run_read("fill", 32'h1234_5678, fill_a, 1'b0);

    // Writeback with two idle cycles between beats.
    u_if.address_i = 32'hCAFE_BABF;
    u_if.line_i    = wb_a;
    u_if.write_i   = 1'b1;
    step();
    n_wr = 0;
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < ((k == 0) ? 0 : 2); g++) begin
        check_eq("wb_burst_gap", u_if.burst_o, wb_a[64*k +: 64]);
        if (u_if.write_o === 1'b1) n_wr++;
        u_if.resp_i = 1'b0;
        step();
      end
      check_eq("wb_burst_ack", u_if.burst_o, wb_a[64*k +: 64]);
      check_eq("wb_addr_o", u_if.address_o, 32'hCAFE_BAA0);
      if (u_if.write_o === 1'b1) n_wr++;
      u_if.resp_i = 1'b1;
      step();
    end
    check_eq("wb_write_cycles", n_wr, 10);
    check_eq("wb_resp_o", u_if.resp_o, 1'b1);
    check_eq("wb_write_o_done", u_if.write_o, 1'b0);
    check_eq("wb_burst_o_done", u_if.burst_o, 64'd0);
    check_eq("wb_line_o_kept", u_if.line_o, fill_a);
    u_if.write_i = 1'b0;
    u_if.resp_i  = 1'b0;
    step();
    check_eq("wb_resp_o_after", u_if.resp_o, 1'b0);

    // Simultaneous read and write: write first, read stays pending.
    resp_mark      = n_resp;
    u_if.address_i = 32'h0000_1040;
    u_if.line_i    = wb_b;
    u_if.write_i   = 1'b1;
    u_if.read_i    = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      check_eq("both_write_o", u_if.write_o, 1'b1);
      check_eq("both_read_o_wr", u_if.read_o, 1'b0);
      check_eq("both_burst_o", u_if.burst_o, wb_b[64*k +: 64]);
      u_if.resp_i = 1'b1;
      step();
    end
    check_eq("both_wr_resp_o", u_if.resp_o, 1'b1);
    u_if.write_i = 1'b0;
    u_if.resp_i  = 1'b0;
    step();
    check_eq("both_idle_read_o", u_if.read_o, 1'b0);
    check_eq("both_idle_write_o", u_if.write_o, 1'b0);
    run_read("both_rd", 32'h0000_1040, fill_b, 1'b0);
    check_eq("both_resp_count", n_resp - resp_mark, 2);

    // Reset after two beats of a read.
    u_if.address_i = 32'h8000_0020;
    u_if.read_i    = 1'b1;
    step();
    for (int k = 0; k < 2; k++) begin
      u_if.resp_i  = 1'b1;
      u_if.burst_i = 64'h0BAD_0000_0000_0000 + 64'(k);
      step();
    end
    u_if.resp_i = 1'b0;
    u_if.read_i = 1'b0;
    check_eq("mid_read_o_pre", u_if.read_o, 1'b1);
    resp_mark = n_resp;
    #1 reset_n = 1'b0;
    #1;
    check_eq("mid_rst_read_o", u_if.read_o, 1'b0);
    check_eq("mid_rst_addr_o", u_if.address_o, 32'd0);
    check_eq("mid_rst_line_o", u_if.line_o, 256'd0);
    check_eq("mid_rst_resp_o", u_if.resp_o, 1'b0);
    step();
    step();
    reset_n = 1'b1;
    step();
    step();
    check_eq("mid_rst_idle_read_o", u_if.read_o, 1'b0);
    check_eq("mid_rst_no_resp", n_resp - resp_mark, 0);
    run_read("post_rst", 32'h8000_0020, fill_c, 1'b1);

    // Stray acknowledges while idle.
    for (int k = 0; k < 8; k++) begin
      u_if.resp_i  = 1'($urandom_range(0, 1));
      u_if.burst_i = {$urandom, $urandom};
      step();
      check_eq("idle_read_o", u_if.read_o, 1'b0);
      check_eq("idle_write_o", u_if.write_o, 1'b0);
    end
    u_if.resp_i = 1'b0;
    step();
    check_eq("idle_line_held", u_if.line_o, fill_c);
    check_eq("idle_resp_o", u_if.resp_o, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cacheline_adaptor.md
CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 Parameters: none; line width is fixed at 256 bits, beat width at 64 bits, and beats per line at 4.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 address_i  input  32  cache-side line address.
REQ-005 read_i  input  1  cache-side line read request; held by the cache until resp_o.
REQ-006 write_i  input  1  cache-side line writeback request; held by the cache until resp_o.
REQ-007 line_i  input  256  writeback line data; beat k = bits [64k+63:64k].
REQ-008 line_o  output  256  assembled fill line.
REQ-009 resp_o  output  1  one-cycle completion pulse to the cache.
REQ-010 address_o  output  32  memory-side burst address.
REQ-011 read_o  output  1  memory-side burst read request.
REQ-012 write_o  output  1  memory-side burst write request.
REQ-013 burst_o  output  64  memory-side write beat.
REQ-014 burst_i  input  64  memory-side read beat.
REQ-015 resp_i  input  1  memory-side per-beat acknowledge; beats may be non-contiguous.

Function
REQ-016 The FSM shall have exactly the states IDLE, READ, WRITE and DONE.
REQ-017 In IDLE, a high write_i shall capture line_i and address_i and transition to WRITE on the same edge.
REQ-018 In IDLE, a high read_i with write_i low shall capture address_i and transition to READ.
REQ-019 When write_i and read_i are both high in IDLE, the write shall take priority and the read shall remain pending.
REQ-020 address_o shall equal {captured address[31:5], 5'b0} during READ and WRITE, and 0 otherwise.
REQ-021 read_o shall be high exactly while the state is READ, and write_o exactly while the state is WRITE.
REQ-022 A 2-bit beat counter shall reset to 0 on entry to READ or WRITE and increment on each cycle in which resp_i is high in that state.
REQ-023 In READ, a high resp_i shall store burst_i into line_o beat slot [counter].
REQ-024 In WRITE, burst_o shall present beat [counter] of the captured line; in all other states burst_o shall be 0.
REQ-025 When resp_i is high with the counter at 3, the FSM shall go to DONE.
REQ-026 resp_o shall be high exactly while the state is DONE, which lasts one cycle and then always returns to IDLE.
REQ-027 line_o shall be stable and complete during DONE, and shall hold its value until the next READ overwrites it.
REQ-028 Beats written to line_o during READ shall change only the addressed slot.
REQ-029 resp_i shall be ignored in IDLE and DONE.
REQ-030 read_i and write_i shall be ignored outside IDLE.
REQ-031 Because a request still high during DONE is not sampled, a new request shall be accepted no earlier than the first IDLE cycle after DONE.
REQ-032 Minimum latency with contiguous resp_i: request seen in IDLE at cycle 0, beats in cycles 1-4, resp_o in cycle 5, IDLE in cycle 6.

Reset
REQ-033 Asserting reset_n low shall immediately force the following values, regardless of clk or the current state:
- state = IDLE, counter = 0;
- read_o = 0, write_o = 0, resp_o = 0;
- address_o = 0, burst_o = 0;
- line_o = 0 and the captured line = 0.
REQ-034 A reset asserted mid-burst shall abandon the burst with no resp_o pulse, and after release the block shall respond only to new requests sampled in IDLE.

Verification
REQ-035 Read fill, address_i = 0x1234_5678, resp_i contiguous, burst_i = 0xA0..A3 patterns -> read_o cycles 1-4, address_o = 0x1234_5660, resp_o only in cycle 5, line_o = {A3,A2,A1,A0}.
REQ-036 Writeback, line_i = 256'h0123...EF (four distinct beats), resp_i with 2-cycle gaps between beats -> burst_o holds each beat until its resp_i, write_o stays high for 10 cycles, then one resp_o pulse.
REQ-037 read_i and write_i both high in IDLE -> the writeback completes first (resp_o), then the read burst starts in the cycle after the next IDLE sampling; two resp_o pulses total.
REQ-038 reset_n pulsed low after beat 2 of a read -> all outputs 0 asynchronously, no resp_o, and a following read completes normally with fresh data in all four slots.
REQ-039 resp_i toggled randomly while IDLE and during DONE -> no state change, line_o unchanged, read_o and write_o stay 0.
